// File: rtl/capture_ctrl_pkg.sv
// Shared types and helpers for the capture/readout controller.
// - state_e        : sequencer states
// - BYTE_W         : width of one stream byte
// - bytes_per_word : number of stream bytes per RAM word
package capture_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StFetch,
    StLoad,
    StSend
  } state_e;

  localparam int unsigned BYTE_W = 8;

  function automatic int unsigned bytes_per_word(input int unsigned width);
    return width / BYTE_W;
  endfunction

endpackage

// File: rtl/capture_readout_ctrl_if.sv
// Bundle of the sample-source, RAM and UART TX stream signals around the controller.
// master : controller side (drives RAM write/read address and the TX stream)
// slave  : environment side (sample source, RAM model, UART TX)
interface capture_readout_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 10
);

  // Sample source
  logic [DATA_WIDTH-1:0] sample_data;
  logic                  sample_valid;

  // Simple dual-port RAM
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_q;

  // Byte stream to UART TX
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    input  sample_data,
    input  sample_valid,
    output ram_we,
    output ram_waddr,
    output ram_wdata,
    output ram_raddr,
    input  ram_q,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    output sample_data,
    output sample_valid,
    input  ram_we,
    input  ram_waddr,
    input  ram_wdata,
    input  ram_raddr,
    output ram_q,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/word_byte_serializer.sv
// Splits one RAM word into bytes, most significant byte first, on a valid/ready stream.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   load_i        : capture load_data_i and restart the byte count
//   load_data_i   : word to serialize
//   send_i        : stream stage is offering the current byte
//   tx_ready_i    : sink accepts the byte
//   tx_data_o     : current byte (top byte of the shift register)
//   tx_valid_o    : byte valid
//   fire_o        : handshake this cycle
//   last_o        : current byte is the final byte of the word
module word_byte_serializer
  import capture_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic                  send_i,
  input  logic                  tx_ready_i,
  output logic [BYTE_W-1:0]     tx_data_o,
  output logic                  tx_valid_o,
  output logic                  fire_o,
  output logic                  last_o
);

  localparam int unsigned NBytes = bytes_per_word(DATA_WIDTH);
  localparam int unsigned CntW   = $clog2(NBytes + 1);

  logic [DATA_WIDTH-1:0] shift_q;
  logic [CntW-1:0]       bcnt_q;

  // Shift register only moves on a handshake, so the byte holds while stalled.
  assign tx_valid_o = send_i;
  assign fire_o     = send_i & tx_ready_i;
  assign tx_data_o  = shift_q[DATA_WIDTH-1 -: BYTE_W];
  assign last_o     = (bcnt_q == CntW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      bcnt_q  <= '0;
    end else if (load_i) begin
      shift_q <= load_data_i;
      bcnt_q  <= CntW'(NBytes);
    end else if (fire_o) begin
      shift_q <= shift_q << BYTE_W;
      bcnt_q  <= bcnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/capture_readout_ctrl.sv
// Capture/readout sequencer: on start fills the whole sample RAM through the write port,
// then reads every word back and streams it MSB-byte-first to the UART TX path.
// Ports:
//   clk, rst_n : single clock (also clocks the RAM), asynchronous active-low reset
//   start      : begin a capture, honoured only when idle
//   abort      : return to idle from any state, wins over start
//   busy       : high whenever not idle
//   done       : one-cycle pulse after the final byte handshake
//   bus        : sample source, RAM ports and TX byte stream (master side)
module capture_readout_ctrl
  import capture_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  capture_readout_ctrl_if.master bus
);

  if ((DATA_WIDTH == 0) || ((DATA_WIDTH % BYTE_W) != 0)) begin : g_width_check
    $error("capture_readout_ctrl: DATA_WIDTH must be a non-zero multiple of 8");
  end

  localparam logic [ADDR_WIDTH-1:0] LastAddr = {ADDR_WIDTH{1'b1}};

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] wptr_q;
  logic [ADDR_WIDTH-1:0] rptr_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic                  done_q;

  logic                  ser_load;
  logic                  ser_send;
  logic                  ser_fire;
  logic                  ser_last;
  logic                  ser_valid;
  logic [BYTE_W-1:0]     ser_data;

  assign ser_load = (state_q == StLoad);
  assign ser_send = (state_q == StSend);

  word_byte_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_serializer (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (ser_load),
    .load_data_i (bus.ram_q),
    .send_i      (ser_send),
    .tx_ready_i  (bus.tx_ready),
    .tx_data_o   (ser_data),
    .tx_valid_o  (ser_valid),
    .fire_o      (ser_fire),
    .last_o      (ser_last)
  );

  // All decoded outputs depend on registered state; only ram_we also gates on sample_valid.
  assign bus.ram_we    = (state_q == StCapture) & bus.sample_valid;
  assign bus.ram_waddr = wptr_q;
  assign bus.ram_wdata = bus.sample_data;
  assign bus.ram_raddr = raddr_q;
  assign bus.tx_data   = ser_data;
  assign bus.tx_valid  = ser_valid;
  assign busy          = (state_q != StIdle);
  assign done          = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      rptr_q  <= '0;
      raddr_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              state_q <= StCapture;
              wptr_q  <= '0;
              rptr_q  <= '0;
            end
          end
          StCapture: begin
            if (bus.sample_valid) begin
              wptr_q <= wptr_q + 1'b1;
              if (wptr_q == LastAddr) begin
                state_q <= StFetch;
                raddr_q <= '0;
              end
            end
          end
          // RAM registers raddr this cycle; its output is valid in StLoad.
          StFetch: state_q <= StLoad;
          StLoad:  state_q <= StSend;
          StSend: begin
            if (ser_fire && ser_last) begin
              if (rptr_q == LastAddr) begin
                state_q <= StIdle;
                done_q  <= 1'b1;
              end else begin
                rptr_q  <= rptr_q + 1'b1;
                raddr_q <= rptr_q + 1'b1;
                state_q <= StFetch;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_readout_ctrl.sv
module tb_capture_readout_ctrl;

  localparam int DW     = 16;
  localparam int AW     = 2;
  localparam int NWORDS = 4;
  localparam int BPW    = DW / 8;
  localparam int NBYTES = NWORDS * BPW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy;
  logic done;

  capture_readout_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  capture_readout_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: write port plus registered read port.
  logic [DW-1:0] mem [NWORDS];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
    bus.ram_q <= mem[bus.ram_raddr];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction log filled by the monitor.
  logic [AW-1:0] wr_addr_q [$];
  logic [DW-1:0] wr_data_q [$];
  logic [7:0]    tx_q      [$];
  int            last_hs_cyc, last_wr_cyc, done_cyc, done_cnt, stall_obs;
  logic          prev_stall = 1'b0;
  logic          prev_abort = 1'b0;
  logic [7:0]    prev_data  = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !prev_abort) begin
        check("stream_hold_valid", 32'(bus.tx_valid), 32'd1);
        check("stream_hold_data", 32'(bus.tx_data), 32'(prev_data));
      end
      if (bus.ram_we) begin
        wr_addr_q.push_back(bus.ram_waddr);
        wr_data_q.push_back(bus.ram_wdata);
        last_wr_cyc = cyc;
      end
      if (bus.tx_valid && bus.tx_ready) begin
        tx_q.push_back(bus.tx_data);
        last_hs_cyc = cyc;
      end
      if (bus.tx_valid && !bus.tx_ready && bus.tx_data == 8'h56) stall_obs++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_low_with_done", 32'(busy), 32'd0);
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
      prev_abort = abort;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    tx_q.delete();
    done_cnt  = 0;
    stall_obs = 0;
  endtask

  // Reference: each captured word becomes BPW bytes, most significant first.
  function automatic logic [63:0] model_bytes(input logic [63:0] words);
    logic [7:0]    q [$];
    logic [DW-1:0] w;
    logic [63:0]   r;
    for (int k = 0; k < NWORDS; k++) begin
      w = words[63-16*k -: 16];
      for (int b = 0; b < BPW; b++) q.push_back(8'(w >> (8 * (BPW - 1 - b))));
    end
    r = '0;
    for (int i = 0; i < q.size(); i++) r = {r[55:0], q[i]};
    return r;
  endfunction

  task automatic run_job(input logic [63:0] words, input int gap, input int stall_idx,
                         input int stall_len, input bit extra_start, input bit rand_ready,
                         input logic [63:0] exp_bytes, input string tag);
    int   fi;
    int   gap_left;
    int   stalled;
    bit   got_done;
    logic [31:0] act;
    fi = 0; gap_left = gap; stalled = 0; got_done = 1'b0;
    tick();
    clear_log();
    start = 1'b1; bus.sample_valid = 1'b0; bus.tx_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      start = extra_start && (i % 3 == 0);
      if (fi < NWORDS) begin
        if (gap_left > 0) begin
          bus.sample_valid = 1'b0;
          bus.sample_data  = 16'($urandom);
          gap_left--;
        end else begin
          bus.sample_valid = 1'b1;
          bus.sample_data  = words[63-16*fi -: 16];
          fi++;
          gap_left = gap;
        end
      end else begin
        bus.sample_valid = 1'($urandom);
        bus.sample_data  = 16'($urandom);
      end
      if (rand_ready) begin
        bus.tx_ready = ($urandom_range(0, 3) != 0);
      end else if (stall_idx >= 0 && tx_q.size() == stall_idx && bus.tx_valid &&
                   stalled < stall_len) begin
        bus.tx_ready = 1'b0;
        stalled++;
      end else begin
        bus.tx_ready = 1'b1;
      end
      tick();
    end
    start = 1'b0; bus.sample_valid = 1'b0; bus.tx_ready = 1'b1;
    tick();
    tick();
    check({tag, "_done_seen"}, 32'(got_done), 32'd1);
    check({tag, "_write_count"}, 32'(wr_addr_q.size()), 32'(NWORDS));
    for (int k = 0; k < NWORDS; k++) begin
      act = (k < wr_addr_q.size()) ? 32'(wr_addr_q[k]) : 'x;
      check({tag, "_write_addr"}, act, 32'(k));
      act = (k < wr_data_q.size()) ? 32'(wr_data_q[k]) : 'x;
      check({tag, "_write_data"}, act, 32'(words[63-16*k -: 16]));
    end
    check({tag, "_tx_count"}, 32'(tx_q.size()), 32'(NBYTES));
    for (int i = 0; i < NBYTES; i++) begin
      act = (i < tx_q.size()) ? 32'(tx_q[i]) : 'x;
      check({tag, "_tx_byte"}, act, 32'(exp_bytes[63-8*i -: 8]));
    end
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_after_last_byte"}, 32'(done_cyc), 32'(last_hs_cyc + 1));
    if (!rand_ready && stall_len == 0)
      check({tag, "_throughput"}, 32'(done_cyc - last_wr_cyc), 32'(NWORDS * (BPW + 2) + 1));
    if (stall_len > 0)
      check({tag, "_stall_cycles"}, 32'(stall_obs), 32'(stall_len));
  endtask

  typedef struct {
    logic [63:0] words;
    int          gap;
    int          stall_idx;
    int          stall_len;
    bit          extra_start;
    logic [63:0] exp_bytes;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w;
    bit          found;

    vecs[0] = '{words: 64'h1234_5678_9ABC_DEF0, gap: 2, stall_idx: -1, stall_len: 0,
                extra_start: 1'b0, exp_bytes: 64'h12_34_56_78_9A_BC_DE_F0};
    vecs[1] = '{words: 64'h1234_5678_9ABC_DEF0, gap: 1, stall_idx: 2, stall_len: 5,
                extra_start: 1'b0, exp_bytes: 64'h12_34_56_78_9A_BC_DE_F0};
    vecs[2] = '{words: 64'h1234_5678_9ABC_DEF0, gap: 2, stall_idx: -1, stall_len: 0,
                extra_start: 1'b1, exp_bytes: 64'h12_34_56_78_9A_BC_DE_F0};
    vecs[3] = '{words: 64'hA5A5_0001_FF00_8000, gap: 0, stall_idx: -1, stall_len: 0,
                extra_start: 1'b0, exp_bytes: 64'hA5_A5_00_01_FF_00_80_00};

    bus.sample_valid = 1'b1;
    bus.sample_data  = 16'hFFFF;
    bus.tx_ready     = 1'b1;

    // Reset state
    #2;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_ram_we", 32'(bus.ram_we), 32'd0);
    check("reset_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("reset_tx_data", 32'(bus.tx_data), 32'd0);
    check("reset_ram_raddr", 32'(bus.ram_raddr), 32'd0);
    check("reset_ram_waddr", 32'(bus.ram_waddr), 32'd0);
    #20;
    rst_n = 1'b1;
    bus.sample_valid = 1'b0;

    // Table-driven jobs
    for (int v = 0; v < 4; v++)
      run_job(vecs[v].words, vecs[v].gap, vecs[v].stall_idx, vecs[v].stall_len,
              vecs[v].extra_start, 1'b0, vecs[v].exp_bytes, $sformatf("vec%0d", v));

    // Abort during SEND, after the second byte
    tick();
    clear_log();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < NWORDS; k++) begin
      bus.sample_valid = 1'b1;
      bus.sample_data  = vecs[0].words[63-16*k -: 16];
      tick();
    end
    bus.sample_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (tx_q.size() == 2 && bus.tx_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("abort_reached_send", 32'(found), 32'd1);
    bus.tx_ready = 1'b0;
    bus.sample_valid = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("abort_ram_we", 32'(bus.ram_we), 32'd0);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("abort_stays_idle", 32'(busy), 32'd0);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_bytes_sent", 32'(tx_q.size()), 32'd2);
    bus.sample_valid = 1'b0;
    w = 64'hCAFE_0BAD_F00D_7E57;
    run_job(w, 1, -1, 0, 1'b0, 1'b0, model_bytes(w), "after_abort");

    // Asynchronous reset mid-capture
    tick();
    clear_log();
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.sample_valid = 1'b1;
    bus.sample_data  = 16'h1111;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_ram_we", 32'(bus.ram_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    tick();
    #2;
    rst_n = 1'b1;
    clear_log();
    for (int i = 0; i < 6; i++) tick();
    check("rst_needs_start_busy", 32'(busy), 32'd0);
    check("rst_needs_start_writes", 32'(wr_addr_q.size()), 32'd0);
    bus.sample_valid = 1'b0;

    // start together with abort in IDLE
    clear_log();
    start = 1'b1;
    abort = 1'b1;
    bus.sample_valid = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check("start_abort_still_idle", 32'(busy), 32'd0);
    check("start_abort_no_writes", 32'(wr_addr_q.size()), 32'd0);
    bus.sample_valid = 1'b0;

    // Randomized jobs against the reference model
    for (int r = 0; r < 6; r++) begin
      w = {$urandom, $urandom};
      run_job(w, $urandom_range(0, 3), -1, 0, 1'($urandom), 1'b1, model_bytes(w),
              $sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/capture_readout_ctrl.md
Name: capture_readout_ctrl

Overview:
Single-clock sequencer for the simple dual-port sample RAM: on `start` it fills the whole RAM with incoming samples through the write port. It then reads every word back through the read port and serializes each word MSB-byte-first onto a byte-wide valid/ready stream feeding the UART transmitter. It is the controller between the sample source, the RAM and the UART TX path in the capture/readout demo.

Parameters:
DATA_WIDTH, 16, sample/RAM word width; must be a multiple of 8 (elaboration error otherwise)
ADDR_WIDTH, 10, RAM address width; capture depth = 2**ADDR_WIDTH words

Ports:
clk  in  1  single clock; also drives both RAM clocks
rst_n  in  1  asynchronous, active-low reset
start  in  1  begin capture; honoured only in IDLE
abort  in  1  return to IDLE from any state; wins over start
sample_data  in  DATA_WIDTH  sample word
sample_valid  in  1  sample_data valid this cycle
ram_we  out  1  RAM write enable
ram_waddr  out  ADDR_WIDTH  RAM write address
ram_wdata  out  DATA_WIDTH  RAM write data
ram_raddr  out  ADDR_WIDTH  RAM read address (registered)
ram_q  in  DATA_WIDTH  RAM read data, 1-cycle registered latency
tx_data  out  8  byte to UART TX
tx_valid  out  1  tx_data valid
tx_ready  in  1  UART TX accepts byte
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse after the final byte handshake

Behaviour:
- Reset (async, rst_n=0): state=IDLE; wptr, rptr, ram_raddr, shift register and byte counter = 0; ram_we=0, tx_valid=0, tx_data=0, busy=0, done=0. Reset mid-operation aborts immediately; no done pulse.
- Decoded outputs derive from registered state only:
  - ram_we = (state==CAPTURE) & sample_valid
  - ram_waddr = wptr
  - ram_wdata = sample_data
  - tx_valid = (state==SEND)
  - tx_data = shift[DATA_WIDTH-1 -: 8]
- States:
  - IDLE: start & !abort -> CAPTURE, wptr<=0, rptr<=0.
  - CAPTURE: on each sample_valid cycle, write at wptr, wptr++. A write with wptr==2**ADDR_WIDTH-1 -> FETCH, ram_raddr<=0. If sample_valid=0, no write and wptr holds.
  - FETCH: one cycle while the RAM registers ram_raddr. -> LOAD.
  - LOAD: shift<=ram_q, bcnt<=DATA_WIDTH/8. -> SEND.
  - SEND: tx_valid=1. On tx_valid&tx_ready: shift<<=8, bcnt--.
    - If bcnt==1 and rptr==last: -> IDLE, done<=1 next cycle.
    - If bcnt==1 and rptr!=last: rptr++, ram_raddr<=rptr+1 -> FETCH.
    - Otherwise stay in SEND.
- Stream rule: tx_data and tx_valid stay stable while tx_valid & !tx_ready.
- start outside IDLE is ignored.
- abort in any state -> IDLE at the next edge, with tx_valid=0 and ram_we=0 from that cycle. No done pulse.
- Pointer wrap: pointers never wrap mid-operation. Terminal detection uses equality with 2**ADDR_WIDTH-1.
- Throughput: DATA_WIDTH/8 + 2 cycles per word with tx_ready held high.

Decomposition:
- Package capture_ctrl_pkg: state enum typedef (IDLE, CAPTURE, FETCH, LOAD, SEND), a BYTE_W=8 constant, and a bytes-per-word function.
- Sub-module word_byte_serializer: parallel load, MSB-first shift, byte counter, and the valid/ready stage. The FSM instantiates it.

Test Plan:
All scenarios use DATA_WIDTH=16, ADDR_WIDTH=2.
1. start; samples 0x1234, 0x5678, 0x9ABC, 0xDEF0 with sample_valid gaps; tx_ready=1 -> writes to addr 0..3 only on valid cycles; tx bytes 12 34 56 78 9A BC DE F0; done high exactly 1 cycle after the F0 handshake; busy low with done.
2. Scenario 1 with tx_ready held low for 5 cycles on byte 0x56 -> tx_valid=1 and tx_data=0x56 stable all 5 cycles; no byte lost or duplicated.
3. start pulsed during CAPTURE and SEND -> ignored; pointers and output stream unchanged versus scenario 1.
4. abort during SEND after byte 0x34 -> next cycle state IDLE, tx_valid=0, no done. A fresh start then captures from addr 0 and sends the new data in full.
5. rst_n low mid-CAPTURE (asynchronous, between edges) -> ram_we, busy, tx_valid, done go 0 immediately. After release, state is IDLE and start is required to resume.
6. start and abort asserted together in IDLE -> stays IDLE, busy=0.
